// File: rtl/reaction_timer.sv
// rtl/reaction_timer.sv - reaction time measurement from stimulus flag to button press
// Optional BEST_TIME_EN keeps the minimum valid reaction time in best_ms.
module reaction_timer #(
  parameter int TICK_DIV   = 50000,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT_MS = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             led_on,
  input  logic             button,
  output logic             timing,
  output logic             done,
  output logic             false_start,
  output logic             timeout,
  output logic [CNT_W-1:0] time_ms,
  output logic [CNT_W-1:0] best_ms
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]    PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] TMO       = CNT_W'(TIMEOUT_MS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_TIMING,
    S_RESULT
  } state_t;

  state_t           state_q, state_d;
  logic             sync0_q, sync0_d;
  logic             sync1_q, sync1_d;
  logic             prev_q, prev_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] time_q, time_d;
  logic             done_q, done_d;
  logic             fs_q, fs_d;
  logic             to_q, to_d;
`ifdef BEST_TIME_EN
  logic [CNT_W-1:0] best_q, best_d;
`endif

  logic             press;
  logic             tick;
  logic [CNT_W-1:0] time_inc;

  always_comb begin
    state_d  = state_q;
    sync0_d  = button;
    sync1_d  = sync0_q;
    prev_d   = sync1_q;
    presc_d  = presc_q;
    time_d   = time_q;
    done_d   = done_q;
    fs_d     = fs_q;
    to_d     = to_q;
`ifdef BEST_TIME_EN
    best_d   = best_q;
`endif
    press    = sync1_q & ~prev_q;
    tick     = (presc_q == PRESC_MAX);
    time_inc = time_q + CNT_W'(1);

    // Abort wins over everything except reset; time_ms is left for the display.
    if (state_q != S_IDLE && !enable) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      fs_d    = 1'b0;
      to_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_d = S_ARMED;
            time_d  = '0;
            done_d  = 1'b0;
            fs_d    = 1'b0;
            to_d    = 1'b0;
          end
        end
        S_ARMED: begin
          if (press) begin
            state_d = S_RESULT;
            fs_d    = 1'b1;
          end else if (led_on) begin
            state_d = S_TIMING;
            presc_d = '0;
            time_d  = '0;
          end
        end
        S_TIMING: begin
          if (press) begin
            state_d = S_RESULT;
            done_d  = 1'b1;
`ifdef BEST_TIME_EN
            if (time_q < best_q) best_d = time_q;
`endif
          end else begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
              time_d = time_inc;
              if (time_inc == TMO) begin
                state_d = S_RESULT;
                to_d    = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      prev_q  <= 1'b0;
      presc_q <= '0;
      time_q  <= '0;
      done_q  <= 1'b0;
      fs_q    <= 1'b0;
      to_q    <= 1'b0;
`ifdef BEST_TIME_EN
      best_q  <= '1;
`endif
    end else begin
      state_q <= state_d;
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      prev_q  <= prev_d;
      presc_q <= presc_d;
      time_q  <= time_d;
      done_q  <= done_d;
      fs_q    <= fs_d;
      to_q    <= to_d;
`ifdef BEST_TIME_EN
      best_q  <= best_d;
`endif
    end
  end

  assign timing      = (state_q == S_TIMING);
  assign done        = done_q;
  assign false_start = fs_q;
  assign timeout     = to_q;
  assign time_ms     = time_q;
`ifdef BEST_TIME_EN
  assign best_ms     = best_q;
`else
  assign best_ms     = '1;
`endif

endmodule

// File: tb/tb_reaction_timer.sv
// tb/tb_reaction_timer.sv - randomized rounds checked against a cycle-count reference model
module tb_reaction_timer;

  localparam int TD  = 4;
  localparam int CW  = 16;
  localparam int TMO = 20;

  localparam int P_IDLE = 0, P_ARMED = 1, P_TIMING = 2, P_RESULT = 3;
  localparam int R_NONE = 0, R_DONE = 1, R_FS = 2, R_TO = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          led_on = 1'b0;
  logic          button = 1'b0;
  logic          timing, done, false_start, timeout;
  logic [CW-1:0] time_ms, best_ms;

  reaction_timer #(.TICK_DIV(TD), .CNT_W(CW), .TIMEOUT_MS(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .led_on(led_on), .button(button),
    .timing(timing), .done(done), .false_start(false_start), .timeout(timeout),
    .time_ms(time_ms), .best_ms(best_ms)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: phase, result kind, cycles spent in TIMING, raw button history.
  int m_phase = P_IDLE;
  int m_res   = R_NONE;
  int m_cyc   = 0;
  int m_time  = 0;
  int m_best  = 65535;
  bit hist[3] = '{0, 0, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit l, input bit b);
    bit press;
    press = hist[1] && !hist[2];
    if (r) begin
      m_phase = P_IDLE; m_res = R_NONE; m_time = 0; m_best = 65535;
      hist = '{0, 0, 0};
      return;
    end
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = b;
    if (m_phase != P_IDLE && !e) begin
      m_phase = P_IDLE; m_res = R_NONE;
    end else begin
      case (m_phase)
        P_IDLE: if (e) begin m_phase = P_ARMED; m_res = R_NONE; m_time = 0; end
        P_ARMED: begin
          if (press) begin m_phase = P_RESULT; m_res = R_FS; end
          else if (l) begin m_phase = P_TIMING; m_cyc = 0; m_time = 0; end
        end
        P_TIMING: begin
          if (press) begin
            m_phase = P_RESULT; m_res = R_DONE;
            if (m_time < m_best) m_best = m_time;
          end else begin
            m_cyc++;
            m_time = m_cyc / TD;
            if (m_time == TMO) begin m_phase = P_RESULT; m_res = R_TO; end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic verify();
    int exp_best;
`ifdef BEST_TIME_EN
    exp_best = m_best;
`else
    exp_best = 65535;
`endif
    check("timing", 32'(timing), 32'(m_phase == P_TIMING));
    check("done", 32'(done), 32'(m_phase == P_RESULT && m_res == R_DONE));
    check("false_start", 32'(false_start), 32'(m_phase == P_RESULT && m_res == R_FS));
    check("timeout", 32'(timeout), 32'(m_phase == P_RESULT && m_res == R_TO));
    check("time_ms", 32'(time_ms), 32'(m_time));
    check("best_ms", 32'(best_ms), 32'(exp_best));
  endtask

  task automatic cycle(input bit r, input bit e, input bit l, input bit b);
    rst = r; enable = e; led_on = l; button = b;
    model_step(r, e, l, b);
    @(posedge clk);
    @(negedge clk);
    verify();
  endtask

  // Times are round-relative cycle numbers; 1000 means never.
  task automatic run_round(input int led_at, input int press_at, input int hold,
                           input int press2, input int abort_at, input int rst_at,
                           input bit pre, input int len);
    bit b;
    repeat (3) cycle(1'b0, 1'b0, 1'b0, pre);
    for (int c = 0; c < len; c++) begin
      b = pre || (c >= press_at && c < press_at + hold) || (c >= press2 && c < press2 + 2);
      cycle(c == rst_at, !(abort_at >= 0 && c >= abort_at), c >= led_at, b);
    end
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    run_round(10, 49, 3, 1000, -1, -1, 1'b0, 70);
    run_round(10, 3, 2, 30, -1, -1, 1'b0, 60);
    run_round(2, 1000, 1, 1000, -1, -1, 1'b0, 100);
    run_round(2, 1000, 1, 1000, -1, -1, 1'b1, 100);
    run_round(2, 1000, 1, 1000, 23, -1, 1'b0, 30);
    run_round(2, 40, 4, 1000, -1, -1, 1'b0, 60);
    run_round(2, 51, 2, 1000, -1, -1, 1'b0, 70);
    run_round(2, 31, 2, 1000, -1, -1, 1'b0, 50);
    run_round(2, 39, 2, 1000, -1, -1, 1'b0, 60);
    run_round(9, 4, 2, 1000, -1, -1, 1'b0, 30);
    run_round(2, 1000, 1, 1000, -1, 30, 1'b0, 40);

    for (int i = 0; i < 150; i++) begin
      run_round(int'($urandom_range(0, 15)),
                int'($urandom_range(0, 110)),
                int'($urandom_range(1, 10)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 100)) : 1000,
                ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 100)) : -1,
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 100)) : -1,
                $urandom_range(0, 9) == 0,
                int'($urandom_range(20, 110)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
